// File: rtl/stopwatch_btn_conditioner.sv
// Start/stop push-button conditioner for the stopwatch core.
// Each button goes through a sync -> debounce FSM channel. The stop channel also has a long-press detector.

// One button channel: a two-flop synchroniser followed by a debounce/hold FSM.
// state        | meaning
// IDLE         | debounced released
// PRESS_WAIT   | candidate press, debounce counter running
// HELD         | debounced pressed
// RELEASE_WAIT | candidate release, debounce counter running
module stopwatch_btn_channel #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pulse_nxt;
  logic            sync_q1, sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync_q2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync_q2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q2) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Level is a decode of the state register, so there is no path from the pin to the output.
  assign level = (state == HELD) || (state == RELEASE_WAIT);

endmodule

module stopwatch_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LONG_CYCLES     = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic start_pulse,
  output logic stop_pulse,
  output logic stop_long,
  output logic start_level,
  output logic stop_level
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;

  stopwatch_btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (start),
    .pulse (start_pulse),
    .level (start_level)
  );

  stopwatch_btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (stop),
    .pulse (stop_pulse),
    .level (stop_level)
  );

  // The hold counter sits at zero while stop is debounced-released. It therefore starts from zero on every
  // accepted press. Release glitches stay in RELEASE_WAIT, where the level is still high, so they do not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      stop_long <= 1'b0;
    end else begin
      stop_long <= stop_level && (hold_cnt == HOLD_FIRE);
      if (!stop_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
